// File: rtl/otter_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : otter_muldiv
// Brief    : RV32M iterative multiply/divide unit with a fixed 32-cycle latency.
//            The divider datapath exists only when OTTER_MULDIV_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module otter_muldiv (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [4:0]  i_rd,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_w_en,
  output logic [4:0]  o_rd,
  output logic [31:0] o_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_pend_q, rd_pend_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] b_q, b_d;

  logic        w_sgn_a, w_sgn_b;
  logic [32:0] w_msum;
  logic [31:0] w_step_acc, w_step_lo;
  logic [63:0] w_prod, w_prod_s;
  logic [31:0] w_final;
`ifdef OTTER_MULDIV_DIV_EN
  logic [32:0] w_rshift;
  logic        w_fits;
`endif

  // Shared datapath: acc/lo is the 64-bit product for multiply, or the
  // partial remainder / dividend-into-quotient pair for divide.
  always_comb begin
    w_msum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
    w_step_acc = w_msum[32:1];
    w_step_lo  = {w_msum[0], lo_q[31:1]};
`ifdef OTTER_MULDIV_DIV_EN
    w_rshift = {acc_q, lo_q[31]};
    w_fits   = (w_rshift >= {1'b0, b_q});
    if (funct3_q[2]) begin
      w_step_acc = w_fits ? (w_rshift[31:0] - b_q) : w_rshift[31:0];
      w_step_lo  = {lo_q[30:0], w_fits};
    end
`endif
  end

  always_comb begin
    w_prod   = {w_step_acc, w_step_lo};
    w_prod_s = (neg_a_q ^ neg_b_q) ? (64'd0 - w_prod) : w_prod;
    case (funct3_q)
      3'b000:                 w_final = w_prod_s[31:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_s[63:32];
      default: begin
`ifdef OTTER_MULDIV_DIV_EN
        // Divide-by-zero quotient must stay all-ones, so it is never negated.
        if (funct3_q[1])
          w_final = neg_a_q ? (32'd0 - w_step_acc) : w_step_acc;
        else if ((neg_a_q ^ neg_b_q) && (b_q != 32'd0))
          w_final = 32'd0 - w_step_lo;
        else
          w_final = w_step_lo;
`else
        w_final = 32'd0;
`endif
      end
    endcase
  end

  always_comb begin
    w_sgn_a   = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    w_sgn_b   = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) ||
                (i_funct3 == 3'b110);
    state_d   = state_q;
    cnt_d     = cnt_q;
    funct3_d  = funct3_q;
    rd_pend_d = rd_pend_q;
    rd_d      = rd_q;
    result_d  = result_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    b_d       = b_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d   = RUN;
          cnt_d     = 5'd31;
          funct3_d  = i_funct3;
          rd_pend_d = i_rd;
          neg_a_d   = w_sgn_a & i_rs1[31];
          neg_b_d   = w_sgn_b & i_rs2[31];
          acc_d     = 32'd0;
          lo_d      = (w_sgn_a & i_rs1[31]) ? (32'd0 - i_rs1) : i_rs1;
          b_d       = (w_sgn_b & i_rs2[31]) ? (32'd0 - i_rs2) : i_rs2;
        end
      end
      RUN: begin
        acc_d = w_step_acc;
        lo_d  = w_step_lo;
        if (cnt_q == 5'd0) begin
          state_d  = DONE;
          result_d = w_final;
          rd_d     = rd_pend_q;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      funct3_q  <= 3'd0;
      rd_pend_q <= 5'd0;
      rd_q      <= 5'd0;
      result_q  <= 32'd0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      acc_q     <= 32'd0;
      lo_q      <= 32'd0;
      b_q       <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      rd_pend_q <= rd_pend_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      b_q       <= b_d;
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_done   = (state_q == DONE);
  assign o_w_en   = (state_q == DONE);
  assign o_rd     = rd_q;
  assign o_result = result_q;

endmodule
`default_nettype wire

// File: doc/otter_muldiv.md
OTTER_MULDIV -- requirements
Module: otter_muldiv

Interface
REQ-001 The block SHALL have one clock, i_clk; reset i_rst SHALL be asynchronous and active-high.
REQ-002 The block SHALL have no parameters; data width is fixed at 32 bits.
REQ-003 The ports SHALL be, in order:
  i_clk  in  1  rising-edge clock
  i_rst  in  1  async active-high reset
  i_start  in  1  request strobe; sampled only in IDLE
  i_funct3  in  3  RV32M op select
  i_rs1  in  32  operand A (register-file read port 1)
  i_rs2  in  32  operand B (register-file read port 2)
  i_rd  in  5  destination register
  o_busy  out  1  unit occupied
  o_done  out  1  one-cycle result-valid pulse
  o_w_en  out  1  register-file write enable (equals o_done)
  o_rd  out  5  latched destination; drives register-file write address
  o_result  out  32  result; drives register-file write data

Function
REQ-004 The i_funct3 encoding SHALL be: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU (RISC-V M semantics).
REQ-005 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-006 In IDLE with i_start=1 at edge E0, the block SHALL latch i_funct3, i_rd, and the operand magnitudes plus sign flags, set a 5-bit counter to 31, and enter RUN.
REQ-007 In RUN, each edge SHALL perform one iteration: shift-add for multiply, restoring shift-subtract for divide. The counter SHALL decrement, and the state SHALL go to DONE on the edge at which the counter equals 0 (E32).
REQ-008 o_done and o_w_en SHALL be high for exactly the one cycle spent in DONE (between E32 and E33). DONE SHALL always return to IDLE at the next edge.
REQ-009 Latency SHALL be fixed at 32 cycles from the accept edge to o_done visible, for every op and operand value, including special cases.
REQ-010 o_busy SHALL be 1 in RUN and DONE and 0 in IDLE. i_start SHALL be ignored whenever the state is not IDLE.
REQ-011 MULH, MULHSU and MULHU SHALL return bits [63:32] of the signed×signed, signed×unsigned and unsigned×unsigned product respectively. MUL SHALL return bits [31:0].
REQ-012 For signed ops, the block SHALL operate on magnitudes and apply the sign correction to the 64-bit product or the quotient/remainder in the DONE transition. The remainder SHALL take the sign of the dividend.
REQ-013 Divide by zero SHALL give: DIV/DIVU = 0xFFFFFFFF; REM/REMU = the dividend.
REQ-014 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give: DIV = 0x80000000; REM = 0x00000000.
REQ-015 o_result and o_rd SHALL update only on entry to DONE and SHALL then hold until the next entry to DONE or reset.
REQ-016 o_w_en SHALL assert even when o_rd = 0; suppressing writes to x0 is the register file's responsibility.

Reset
REQ-017 While i_rst=1, the block SHALL hold: state IDLE, o_busy 0, o_done 0, o_w_en 0, o_rd 0, o_result 0x00000000, and counter 0.
REQ-018 Reset asserted during RUN or DONE SHALL abort the operation immediately. No o_done pulse SHALL follow for the aborted op.
REQ-019 The first accept SHALL be possible at the first rising edge after i_rst deasserts.

Configuration
REQ-020 With macro OTTER_MULDIV_DIV_EN defined, all eight ops SHALL be implemented as specified above.
REQ-021 Without OTTER_MULDIV_DIV_EN, the divider datapath SHALL be absent. Ops 100–111 SHALL still be accepted, still complete with the same 32-cycle latency and o_done pulse, and SHALL return 0x00000000.

Verification
REQ-022 MUL: rs1=7, rs2=0xFFFFFFFD, rd=5 -> o_result=0xFFFFFFEB and o_rd=5, with o_done exactly 32 cycles after accept, high for one cycle.
REQ-023 MULH: 0x80000000 × 0x80000000 -> 0x40000000. MULHU: 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-024 DIV: 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0. DIV: −7 / 2 -> 0xFFFFFFFD; REM on the same operands -> 0xFFFFFFFF.
REQ-025 DIVU: 100 / 0 -> 0xFFFFFFFF; REMU: 100 / 0 -> 100. Without the macro, DIVU 100 / 5 -> 0 after 32 cycles.
REQ-026 Pulse i_start again at cycle 5 of RUN -> ignored, and exactly one o_done follows. Assert i_rst at cycle 10 of RUN -> o_busy=0 immediately, no o_done, o_result=0.
